// File: rtl/vga_timing_pkg.sv
// Shared defaults, total-period helper and the sync/DE bundle type for the raster timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_CNT_W    = 10;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bundle_t;

    function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    function automatic int h_total(input int sync, input int bp, input int active, input int fp);
        return axis_total(sync, bp, active, fp);
    endfunction

    function automatic int v_total(input int sync, input int bp, input int active, input int fp);
        return axis_total(sync, bp, active, fp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter plus sync/active/offset decode of the value it will hold next.
// Lookahead decode exists only when VGA_TIMING_LOOKAHEAD_EN is defined.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter bit POL    = 1'b1,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic [CNT_W-1:0] nxt,
    output logic             sync_nxt,
    output logic             act_nxt,
    output logic [CNT_W-1:0] off_nxt
`ifdef VGA_TIMING_LOOKAHEAD_EN
    ,
    input  logic             la_step,
    output logic             nxt_last,
    output logic             la_act,
    output logic [CNT_W-1:0] la_off
`endif
);

    localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
    // One extra bit so an active window ending exactly at 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0]   SYNC_C  = (CNT_W+1)'(SYNC);
    localparam logic [CNT_W:0]   START_C = (CNT_W+1)'(SYNC + BP);
    localparam logic [CNT_W:0]   END_C   = (CNT_W+1)'(SYNC + BP + ACTIVE);

    logic [CNT_W-1:0] count_r;

    function automatic logic in_active(input logic [CNT_W-1:0] c);
        return ({1'b0, c} >= START_C) && ({1'b0, c} < END_C);
    endfunction

    assign count = count_r;

    // Next-count selection and its decode.
    always_comb begin
        wrap = inc && (count_r == LAST_C);
        nxt  = count_r;
        if (inc) begin
            if (count_r == LAST_C) begin
                nxt = ZERO_C;
            end else begin
                nxt = count_r + ONE_C;
            end
        end else begin
            nxt = count_r;
        end
        sync_nxt = ({1'b0, nxt} < SYNC_C) ? POL : ~POL;
        act_nxt  = in_active(nxt);
        off_nxt  = nxt - START_C[CNT_W-1:0];
    end

    // Axis position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO_C;
        end else begin
            count_r <= nxt;
        end
    end

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [CNT_W-1:0] la_cnt_s;

    // Position one further ce beyond nxt, stepping only when the caller says this axis moves.
    always_comb begin
        nxt_last = (nxt == LAST_C);
        la_cnt_s = nxt;
        if (la_step) begin
            if (nxt == LAST_C) begin
                la_cnt_s = ZERO_C;
            end else begin
                la_cnt_s = nxt + ONE_C;
            end
        end else begin
            la_cnt_s = nxt;
        end
        la_act = in_active(la_cnt_s);
        la_off = la_cnt_s - START_C[CNT_W-1:0];
    end
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator; all outputs registered and aligned with hcount/vcount.
// Optional lookahead outputs enabled by VGA_TIMING_LOOKAHEAD_EN (otherwise tied to 0).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_FP     = DEF_H_FP,
    parameter bit H_POL    = 1'b1,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_FP     = DEF_V_FP,
    parameter bit V_POL    = 1'b1,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             in_display_area,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             next_in_display_area,
    output logic [CNT_W-1:0] next_x,
    output logic [CNT_W-1:0] next_y
);

    localparam int H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

    if (H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end

    logic             h_wrap_s, v_wrap_s;
    logic [CNT_W-1:0] h_nxt_s, v_nxt_s, h_off_s, v_off_s;
    logic             h_sync_s, v_sync_s, h_act_s, v_act_s;
    logic             v_inc_s;
    logic             de_nxt_s;
    sync_bundle_t     bundle_s;
    sync_bundle_t     bundle_r;
    logic [CNT_W-1:0] pixel_x_r, pixel_y_r;
    logic             line_start_r, frame_start_r;
    logic             la_de_s;
    logic [CNT_W-1:0] la_x_s, la_y_s;
    logic             la_de_r;
    logic [CNT_W-1:0] la_x_r, la_y_r;

    assign v_inc_s = ce && h_wrap_s;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic             h_nxt_last_s, h_la_act_s, v_la_act_s, v_nxt_last_s;
    logic [CNT_W-1:0] h_la_off_s, v_la_off_s;
`endif

    vga_axis_counter #(
        .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .POL(H_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (ce),
        .count    (hcount),
        .wrap     (h_wrap_s),
        .nxt      (h_nxt_s),
        .sync_nxt (h_sync_s),
        .act_nxt  (h_act_s),
        .off_nxt  (h_off_s)
`ifdef VGA_TIMING_LOOKAHEAD_EN
        ,
        .la_step  (1'b1),
        .nxt_last (h_nxt_last_s),
        .la_act   (h_la_act_s),
        .la_off   (h_la_off_s)
`endif
    );

    vga_axis_counter #(
        .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .POL(V_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (v_inc_s),
        .count    (vcount),
        .wrap     (v_wrap_s),
        .nxt      (v_nxt_s),
        .sync_nxt (v_sync_s),
        .act_nxt  (v_act_s),
        .off_nxt  (v_off_s)
`ifdef VGA_TIMING_LOOKAHEAD_EN
        ,
        .la_step  (h_nxt_last_s),
        .nxt_last (v_nxt_last_s),
        .la_act   (v_la_act_s),
        .la_off   (v_la_off_s)
`endif
    );

`ifdef VGA_TIMING_LOOKAHEAD_EN
    // Lookahead pixel; vertical axis steps only when the horizontal one wraps.
    always_comb begin
        la_de_s = h_la_act_s && v_la_act_s;
        if (la_de_s) begin
            la_x_s = h_la_off_s;
            la_y_s = v_la_off_s;
        end else begin
            la_x_s = ZERO_C;
            la_y_s = ZERO_C;
        end
    end
`else
    assign la_de_s = 1'b0;
    assign la_x_s  = ZERO_C;
    assign la_y_s  = ZERO_C;
`endif

    // Decode of the counter values that will be loaded at this edge.
    always_comb begin
        de_nxt_s       = h_act_s && v_act_s;
        bundle_s.hsync = h_sync_s;
        bundle_s.vsync = v_sync_s;
        bundle_s.de    = de_nxt_s;
    end

    // Output registers: reset state is the decode of position (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_r      <= '{hsync: H_POL, vsync: V_POL, de: 1'b0};
            pixel_x_r     <= ZERO_C;
            pixel_y_r     <= ZERO_C;
            line_start_r  <= 1'b1;
            frame_start_r <= 1'b1;
            la_de_r       <= 1'b0;
            la_x_r        <= ZERO_C;
            la_y_r        <= ZERO_C;
        end else begin
            bundle_r      <= bundle_s;
            pixel_x_r     <= de_nxt_s ? h_off_s : ZERO_C;
            pixel_y_r     <= de_nxt_s ? v_off_s : ZERO_C;
            line_start_r  <= (h_nxt_s == ZERO_C);
            frame_start_r <= (h_nxt_s == ZERO_C) && (v_nxt_s == ZERO_C);
            la_de_r       <= la_de_s;
            la_x_r        <= la_x_s;
            la_y_r        <= la_y_s;
        end
    end

    assign hsync                = bundle_r.hsync;
    assign vsync                = bundle_r.vsync;
    assign in_display_area      = bundle_r.de;
    assign pixel_x              = pixel_x_r;
    assign pixel_y              = pixel_y_r;
    assign line_start           = line_start_r;
    assign frame_start          = frame_start_r;
    assign next_in_display_area = la_de_r;
    assign next_x               = la_x_r;
    assign next_y               = la_y_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole frames fit in a short run.
// Expected lookahead behaviour follows VGA_TIMING_LOOKAHEAD_EN as the bench is compiled.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HS = 3, HB = 2, HA = 8, HF = 3;
    localparam int VS = 2, VB = 1, VA = 3, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;
    localparam int CW = 4;

    typedef struct {
        int h; int v;
        bit hs; bit vs; bit de;
        int px; int py;
        bit ls; bit fs;
        bit nde; int nx; int ny;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic [CW-1:0] hcount, vcount, pixel_x, pixel_y, next_x, next_y;
    logic          hsync, vsync, in_display_area, line_start, frame_start, next_in_display_area;

    int   n_cmp = 0;
    int   n_err = 0;
    int   h_m = 0;
    int   v_m = 0;
    exp_t sb_q[$];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF), .H_POL(HP),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF), .V_POL(VP),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .in_display_area(in_display_area), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start),
        .next_in_display_area(next_in_display_area), .next_x(next_x), .next_y(next_y)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (model h=%0d v=%0d)", tag, obs, exp, h_m, v_m);
        end
    endtask

    function automatic bit is_de(input int h, input int v);
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        int   nh, nv;
        e.h  = h;
        e.v  = v;
        e.hs = (h < HS) ? HP : ~HP;
        e.vs = (v < VS) ? VP : ~VP;
        e.de = is_de(h, v);
        e.px = e.de ? h - HS - HB : 0;
        e.py = e.de ? v - VS - VB : 0;
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        nh = (h == HT - 1) ? 0 : h + 1;
        nv = (h == HT - 1) ? ((v == VT - 1) ? 0 : v + 1) : v;
`ifdef VGA_TIMING_LOOKAHEAD_EN
        e.nde = is_de(nh, nv);
        e.nx  = e.nde ? nh - HS - HB : 0;
        e.ny  = e.nde ? nv - VS - VB : 0;
`else
        e.nde = 1'b0;
        e.nx  = 0;
        e.ny  = 0;
`endif
        return e;
    endfunction

    task automatic pop_and_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq("hcount", hcount, e.h);
            check_eq("vcount", vcount, e.v);
            check_eq("hsync", hsync, e.hs);
            check_eq("vsync", vsync, e.vs);
            check_eq("de", in_display_area, e.de);
            check_eq("pixel_x", pixel_x, e.px);
            check_eq("pixel_y", pixel_y, e.py);
            check_eq("line_start", line_start, e.ls);
            check_eq("frame_start", frame_start, e.fs);
            check_eq("next_de", next_in_display_area, e.nde);
            check_eq("next_x", next_x, e.nx);
            check_eq("next_y", next_y, e.ny);
        end
    endtask

    // Drive one clock with the given ce, advance the model, then compare after the edge.
    task automatic step(input bit ce_v);
        @(negedge clk);
        ce = ce_v;
        if (ce_v) begin
            if (h_m == HT - 1) begin
                h_m = 0;
                v_m = (v_m == VT - 1) ? 0 : v_m + 1;
            end else begin
                h_m = h_m + 1;
            end
        end
        sb_q.push_back(model(h_m, v_m));
        @(posedge clk);
        #1;
        pop_and_compare();
    endtask

    initial begin
        int de_cnt;
        int fs_cnt;

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(model(0, 0));
        pop_and_compare();
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous ce across two frames plus a bit; tally DE and frame strobes over one frame.
        de_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 2 * HT * VT + 5; i++) begin
            step(1'b1);
            if (i >= HT * VT && i < 2 * HT * VT) begin
                de_cnt += (in_display_area === 1'b1) ? 1 : 0;
                fs_cnt += (frame_start === 1'b1) ? 1 : 0;
            end
        end
        check_eq("de_per_frame", de_cnt, HA * VA);
        check_eq("fs_per_frame", fs_cnt, 1);

        // ce one-in-four for over a frame: outputs and strobes hold on idle cycles.
        for (int i = 0; i < HT * VT + 3; i++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            step(1'b0);
        end

        // Async reset mid-frame: outputs clear without a clock edge.
        @(negedge clk);
        ce = 1'b0;
        #2;
        rst_n = 1'b0;
        h_m = 0;
        v_m = 0;
        #1;
        sb_q.push_back(model(0, 0));
        pop_and_compare();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        check_eq("resume_h1", hcount, 1);

        // Random ce pattern through frame wraps.
        for (int i = 0; i < 3 * HT * VT; i++) begin
            step(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
